emb_lookup_param: RTL

Parametrised embedding-lookup engine for the training datapath: the next generation of the forward embedding stage. It captures `N` character indices and fetches each index's `EMB_DIM`-element row from the external embedding-weight RAM, `DATA_N` elements per read. It assembles the rows into a flat output vector and holds it, with `valid`, until `run` is released. Compared with the fixed-size forward stage, it adds:
- full parametrisation;
- out-of-range index detection;
- optional padding-token masking.

---
 rtl/emb_lookup_param.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/emb_lookup_param.sv
// Embedding-lookup engine: fetches N rows of EMB_DIM elements from a synchronous weight RAM into a flat vector.
// Optional padding-token masking is enabled by defining EMB_PAD_MASK_EN.
module emb_lookup_param #(
    parameter int N          = 10,
    parameter int CHAR_LEN   = 8,
    parameter int CHAR_NUM   = 200,
    parameter int EMB_DIM    = 24,
    parameter int DATA_N     = 8,
    parameter int DW         = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int PAD_ID     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       run,
    input  logic [N*CHAR_LEN-1:0]      d,
    output logic                       valid,
    output logic [N*EMB_DIM*DW-1:0]    q,
    output logic [ADDR_WIDTH-1:0]      ram_addr,
    input  logic [DATA_N*DW-1:0]       ram_data,
    output logic                       err
);
    localparam int WPC = EMB_DIM / DATA_N;
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int WW  = (WPC > 1) ? $clog2(WPC) : 1;
    localparam int QW  = N * EMB_DIM * DW;
    localparam int RW  = DATA_N * DW;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [N*CHAR_LEN-1:0]  d_q, d_d;
    logic [N-1:0]           skip_q, skip_d, skip_in, oor_in;
    logic [IW-1:0]          i_q, i_d, wi_q, wi_d;
    logic [WW-1:0]          w_q, w_d, ww_q, ww_d;
    logic                   wr_vld_q, wr_vld_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [QW-1:0]          q_q, q_d;
    logic                   first_found, next_found;
    logic [IW-1:0]          first_i, next_i;
    logic [CHAR_LEN-1:0]    cur_char;
    logic                   last_word;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            oor_in[k] = int'(d[k*CHAR_LEN +: CHAR_LEN]) >= CHAR_NUM;
`ifdef EMB_PAD_MASK_EN
            skip_in[k] = oor_in[k] || (d[k*CHAR_LEN +: CHAR_LEN] == CHAR_LEN'(PAD_ID));
`else
            skip_in[k] = oor_in[k];
`endif
        end
    end

    // Skipped characters cost no cycles: counters jump straight to the next readable character.
    always_comb begin
        first_found = 1'b0;
        first_i     = '0;
        next_found  = 1'b0;
        next_i      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (!skip_in[k]) begin
                first_found = 1'b1;
                first_i     = IW'(k);
            end
            if (!skip_q[k] && (k > int'(i_q))) begin
                next_found = 1'b1;
                next_i     = IW'(k);
            end
        end
    end

    assign last_word = (w_q == WW'(WPC - 1));
    assign cur_char  = d_q[int'(i_q)*CHAR_LEN +: CHAR_LEN];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (run) state_d = first_found ? READ : DRAIN;
            READ: begin
                if (!run)                         state_d = IDLE;
                else if (last_word && !next_found) state_d = DRAIN;
            end
            DRAIN:   state_d = run ? DONE : IDLE;
            DONE:    if (!run) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        d_d      = d_q;
        skip_d   = skip_q;
        i_d      = i_q;
        w_d      = w_q;
        wi_d     = i_q;
        ww_d     = w_q;
        wr_vld_d = (state_q == READ);
        valid_d  = valid_q;
        err_d    = err_q;
        q_d      = q_q;
        case (state_q)
            IDLE: begin
                if (run) begin
                    d_d     = d;
                    skip_d  = skip_in;
                    err_d   = |oor_in;
                    q_d     = '0;
                    i_d     = first_i;
                    w_d     = '0;
                    valid_d = 1'b0;
                end
            end
            READ: begin
                if (run) begin
                    if (last_word) begin
                        w_d = '0;
                        i_d = next_i;
                    end else begin
                        w_d = w_q + WW'(1);
                    end
                end
            end
            DRAIN:   if (run) valid_d = 1'b1;
            DONE:    if (!run) valid_d = 1'b0;
            default: ;
        endcase
        // Word returned by the RAM belongs to the address issued on the previous cycle.
        if (wr_vld_q && run && (state_q == READ || state_q == DRAIN))
            q_d[(int'(wi_q)*EMB_DIM + int'(ww_q)*DATA_N)*DW +: RW] = ram_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            d_q      <= '0;
            skip_q   <= '0;
            i_q      <= '0;
            w_q      <= '0;
            wi_q     <= '0;
            ww_q     <= '0;
            wr_vld_q <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            q_q      <= '0;
        end else begin
            state_q  <= state_d;
            d_q      <= d_d;
            skip_q   <= skip_d;
            i_q      <= i_d;
            w_q      <= w_d;
            wi_q     <= wi_d;
            ww_q     <= ww_d;
            wr_vld_q <= wr_vld_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            q_q      <= q_d;
        end
    end

    always_comb begin
        ram_addr = '0;
        if (state_q == READ)
            ram_addr = ADDR_WIDTH'(cur_char) * ADDR_WIDTH'(WPC) + ADDR_WIDTH'(w_q);
    end

    assign valid = valid_q;
    assign err   = err_q;
    assign q     = q_q;
endmodule
